// File: rtl/cejmu_uart_rx.sv
// cejmu_uart_rx: 8N1 UART deframer feeding the cejmu core through a one-entry valid/ready holding register
module cejmu_uart_rx #(
    parameter int BIT_CYCLES  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       rx_in,
    output logic [7:0] data_out,
    output logic       data_valid,
    input  logic       data_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);
    localparam int CW = $clog2(BIT_CYCLES);
    localparam logic [CW-1:0] HALF = CW'(BIT_CYCLES / 2 - 1);
    localparam logic [CW-1:0] FULL = CW'(BIT_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync;
    logic [CW-1:0]          cnt;
    logic [2:0]             idx;
    logic [7:0]             sh;
    logic                   rxs;
    logic                   mid;
    logic                   deliver;

    assign rxs     = sync[SYNC_STAGES-1];
    assign mid     = cnt == FULL;
    assign deliver = ena && state == STOP && mid && rxs;
    assign busy    = state != IDLE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync <= '1;
        else        sync <= {sync[SYNC_STAGES-2:0], rx_in};
    end

    // START waits half a bit so every later sample lands mid-bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            sh        <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            cnt       <= cnt + 1'b1;
            if (!ena) begin
                state <= IDLE;
                cnt   <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        cnt <= '0;
                        if (!rxs) state <= START;
                    end
                    START: if (cnt == HALF) begin
                        cnt   <= '0;
                        idx   <= '0;
                        state <= rxs ? IDLE : DATA;
                    end
                    DATA: if (mid) begin
                        cnt <= '0;
                        sh  <= {rxs, sh[7:1]};
                        idx <= idx + 3'd1;
                        if (idx == 3'd7) state <= STOP;
                    end
                    STOP: if (mid) begin
                        cnt       <= '0;
                        state     <= rxs ? IDLE : BREAK;
                        frame_err <= !rxs;
                    end
                    BREAK: begin
                        cnt <= '0;
                        if (rxs) state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out   <= '0;
            data_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= deliver && data_valid && !data_ready;
            if (deliver && (!data_valid || data_ready)) begin
                data_out   <= sh;
                data_valid <= 1'b1;
            end else if (data_ready) begin
                data_valid <= 1'b0;
            end
        end
    end
endmodule
